// File: rtl/mem_rsp_pkg.sv
// Shared types and default widths for the TTW memory responder.
// req_t : one line-read request as it travels through the request FIFO.
// res_t : one response (tag plus line data).
// The PKG_* constants are the default widths used by mem_rsp_model.
package mem_rsp_pkg;

  localparam int PKG_IDX_W = 6;
  localparam int PKG_MCN_W = 58;
  localparam int PKG_DAT_W = 512;

  typedef struct packed {
    logic [PKG_IDX_W-1:0] idx;
    logic [PKG_MCN_W-1:0] mcn;
  } req_t;

  typedef struct packed {
    logic [PKG_IDX_W-1:0] idx;
    logic [PKG_DAT_W-1:0] data;
  } res_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Request FIFO for the memory responder.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   push_i, push_data_i       : write one entry (caller guarantees not full)
//   pop_i, pop_data_o         : head entry, removed when pop_i (caller guarantees not empty)
//   full_o, empty_o, cnt_o    : occupancy, all derived from the registered count
module mem_rsp_fifo
  import mem_rsp_pkg::*;
#(
  parameter int W     = $bits(req_t),
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  slot_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    cnt_d    = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) slot_mem[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = slot_mem[rd_ptr_q];
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign cnt_o      = cnt_q;

  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop_i && empty_o));

endmodule

// File: rtl/mem_rsp_model.sv
// Synthesizable memory responder at the far end of the TTW mem_req/mem_res
// channel. Requests (idx, mcn) are queued, the line store is read when a
// request leaves the FIFO, and (idx, data) comes back in request order after
// LAT pipeline stages plus the output register.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   mem_req_o_valid/ready/bits_idx/mcn : request channel (ready from registered count)
//   mem_res_i_valid/ready/bits_idx/data: response channel (held stable until ready)
//   pre_wr_i_valid/mcn/data            : line-store preload write port, write-first
//   busy_o                             : any request queued, in the pipe or at the output
module mem_rsp_model
  import mem_rsp_pkg::*;
#(
  parameter int IDX_W  = PKG_IDX_W,
  parameter int MCN_W  = PKG_MCN_W,
  parameter int DAT_W  = PKG_DAT_W,
  parameter int MEM_AW = 10,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req_o_valid,
  output logic              mem_req_o_ready,
  input  logic [IDX_W-1:0]  mem_req_o_bits_idx,
  input  logic [MCN_W-1:0]  mem_req_o_bits_mcn,
  output logic              mem_res_i_valid,
  input  logic              mem_res_i_ready,
  output logic [IDX_W-1:0]  mem_res_i_bits_idx,
  output logic [DAT_W-1:0]  mem_res_i_bits_data,
  input  logic              pre_wr_i_valid,
  input  logic [MEM_AW-1:0] pre_wr_i_mcn,
  input  logic [DAT_W-1:0]  pre_wr_i_data,
  output logic              busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  // LAT pipe stages followed by the output register; the last slot is the output.
  localparam int NS = LAT + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [MCN_W-1:0] mcn;
  } lreq_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DAT_W-1:0] data;
  } lres_t;

  lreq_t         push_req, head_req;
  logic          push, pop, full, empty, adv;
  logic [CW-1:0] cnt;

  // Everything downstream of the FIFO moves together or not at all.
  assign adv             = ~mem_res_i_valid | mem_res_i_ready;
  assign mem_req_o_ready = ~full;
  assign push            = mem_req_o_valid & ~full;
  assign pop             = ~empty & adv;

  always_comb begin
    push_req     = '0;
    push_req.idx = mem_req_o_bits_idx;
    push_req.mcn = mem_req_o_bits_mcn;
  end

  mem_rsp_fifo #(
    .W     ($bits(lreq_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .pop_data_o  (head_req),
    .full_o      (full),
    .empty_o     (empty),
    .cnt_o       (cnt)
  );

  // Line store: not reset, survives a reset of the request path.
  logic [DAT_W-1:0] line_mem [2**MEM_AW];

  always_ff @(posedge clock) begin
    if (pre_wr_i_valid) line_mem[pre_wr_i_mcn] <= pre_wr_i_data;
  end

  logic [MEM_AW-1:0] rd_addr;
  logic              in_range;
  logic [DAT_W-1:0]  rd_data;

  // Read at pop time; a preload to the same line in the same cycle wins,
  // and lines beyond the store read as zero.
  always_comb begin
    rd_addr  = head_req.mcn[MEM_AW-1:0];
    in_range = (head_req.mcn[MCN_W-1:MEM_AW] == '0);
    rd_data  = line_mem[rd_addr];
    if (pre_wr_i_valid && (pre_wr_i_mcn == rd_addr)) rd_data = pre_wr_i_data;
    if (!in_range) rd_data = '0;
  end

  logic  vld_q [NS];
  logic  vld_d [NS];
  lres_t res_q [NS];
  lres_t res_d [NS];

  // Stage 0 captures the popped head; later stages shift on adv. Data only
  // moves when the feeding stage is valid, so the output idx holds when idle.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      vld_d[i] = vld_q[i];
      res_d[i] = res_q[i];
    end
    if (adv) begin
      vld_d[0] = pop;
      if (pop) begin
        res_d[0].idx  = head_req.idx;
        res_d[0].data = rd_data;
      end
      for (int i = 1; i < NS; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) res_d[i] = res_q[i-1];
      end
    end
  end

  // ---- pipeline / output register boundary ----
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) vld_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) vld_q[i] <= vld_d[i];
    end
  end

  // Only the output register's payload is cleared on reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NS - 1; i++) res_q[i] <= res_d[i];
    if (reset) res_q[NS-1] <= '0;
    else       res_q[NS-1] <= res_d[NS-1];
  end

  logic any_vld;

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < NS; i++) any_vld = any_vld | vld_q[i];
  end

  assign mem_res_i_valid     = vld_q[NS-1];
  assign mem_res_i_bits_idx  = res_q[NS-1].idx;
  assign mem_res_i_bits_data = res_q[NS-1].data;
  assign busy_o              = (cnt != '0) | any_vld;

  a_out_stable: assert property (@(posedge clock) disable iff (reset)
    (mem_res_i_valid && !mem_res_i_ready) |=>
      (mem_res_i_valid && $stable(mem_res_i_bits_idx) && $stable(mem_res_i_bits_data)));

endmodule

// File: tb/tb_mem_rsp_model.sv
// Self-checking bench for mem_rsp_model: table-driven streaming vectors,
// a response scoreboard, and hand-written sequences for latency, backpressure,
// preload collision, out-of-range lines and reset mid-stream.
module tb_mem_rsp_model;
  import mem_rsp_pkg::*;

  localparam int IDX_W  = 6;
  localparam int MCN_W  = 58;
  localparam int DAT_W  = 512;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx = '0;
  logic [MCN_W-1:0]  req_mcn = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [IDX_W-1:0]  res_idx;
  logic [DAT_W-1:0]  res_data;
  logic              pre_valid = 1'b0;
  logic [MEM_AW-1:0] pre_mcn = '0;
  logic [DAT_W-1:0]  pre_data = '0;
  logic              busy;

  always #5 clock = ~clock;

  mem_rsp_model #(
    .IDX_W (IDX_W), .MCN_W (MCN_W), .DAT_W (DAT_W),
    .MEM_AW(MEM_AW), .DEPTH (DEPTH), .LAT (LAT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_o_valid     (req_valid),
    .mem_req_o_ready     (req_ready),
    .mem_req_o_bits_idx  (req_idx),
    .mem_req_o_bits_mcn  (req_mcn),
    .mem_res_i_valid     (res_valid),
    .mem_res_i_ready     (res_ready),
    .mem_res_i_bits_idx  (res_idx),
    .mem_res_i_bits_data (res_data),
    .pre_wr_i_valid      (pre_valid),
    .pre_wr_i_mcn        (pre_mcn),
    .pre_wr_i_data       (pre_data),
    .busy_o              (busy)
  );

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DAT_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [MCN_W-1:0] mcn;
    logic [DAT_W-1:0] data;
  } vec_t;

  int               n_checks = 0;
  int               n_pass   = 0;
  exp_t             sb_q[$];
  logic [DAT_W-1:0] model_mem [int];
  vec_t             vecs [32];

  task automatic check(input string name, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [DAT_W-1:0] pat(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    return {16{w}};
  endfunction

  function automatic logic [DAT_W-1:0] exp_data(input logic [MCN_W-1:0] m);
    if ((m >> MEM_AW) != '0) return '0;
    return model_mem[int'(m)];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int a, input logic [DAT_W-1:0] d);
    pre_valid = 1'b1;
    pre_mcn   = MEM_AW'(a);
    pre_data  = d;
    tick();
    pre_valid = 1'b0;
    model_mem[a] = d;
  endtask

  // One request, held until accepted (bounded), expected response queued.
  task automatic send(input logic [IDX_W-1:0] i, input logic [MCN_W-1:0] m, input logic [DAT_W-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_idx   = i;
    req_mcn   = m;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", DAT_W'(req_ready), DAT_W'(1));
    sb_q.push_back('{idx: i, data: d});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_busy"}, DAT_W'(busy), DAT_W'(0));
    check({name, "_left"}, DAT_W'(sb_q.size()), DAT_W'(0));
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      check("rsp_expected", DAT_W'(sb_q.size() != 0), DAT_W'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rsp_idx", DAT_W'(res_idx), DAT_W'(e.idx));
        check("rsp_data", res_data, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, acc, gaps;
    logic [DAT_W-1:0] a5, xval;

    a5   = {64{8'hA5}};
    xval = {16{32'hC0FF_EE09}};

    // Test 1: reset
    repeat (3) tick();
    check("rst_ready", DAT_W'(req_ready), DAT_W'(1));
    check("rst_res_valid", DAT_W'(res_valid), DAT_W'(0));
    check("rst_busy", DAT_W'(busy), DAT_W'(0));
    check("rst_res_idx", DAT_W'(res_idx), DAT_W'(0));
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      tick();
      if (res_valid) seen++;
    end
    check("post_rst_quiet", DAT_W'(seen), DAT_W'(0));

    for (int i = 0; i < 16; i++) preload(i, (i == 5) ? a5 : pat(i));

    // Test 2: single read, latency 3 edges after accept, one cycle valid
    res_ready = 1'b1;
    check("t2_ready", DAT_W'(req_ready), DAT_W'(1));
    req_valid = 1'b1;
    req_idx   = 6'd3;
    req_mcn   = 58'd5;
    sb_q.push_back('{idx: 6'd3, data: a5});
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t2_valid_at_%0d", k), DAT_W'(res_valid), DAT_W'(k == 3));
      if (k == 3) begin
        check("t2_idx", DAT_W'(res_idx), DAT_W'(3));
        check("t2_data", res_data, a5);
      end
    end
    wait_drain("t2_drain");

    // Test 3: backpressure until full, output held, then drain in order
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      req_valid = 1'b1;
      req_idx   = IDX_W'(k);
      req_mcn   = MCN_W'(k);
      if (req_ready) begin
        sb_q.push_back('{idx: IDX_W'(k), data: exp_data(MCN_W'(k))});
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    check("t3_accepts", DAT_W'(acc), DAT_W'(DEPTH + LAT + 1));
    check("t3_full_ready", DAT_W'(req_ready), DAT_W'(0));
    repeat (3) tick();
    check("t3_hold_valid", DAT_W'(res_valid), DAT_W'(1));
    check("t3_hold_idx", DAT_W'(res_idx), DAT_W'(0));
    check("t3_hold_data", res_data, model_mem[0]);
    check("t3_hold_busy", DAT_W'(busy), DAT_W'(1));
    check("t3_still_full", DAT_W'(req_ready), DAT_W'(0));
    res_ready = 1'b1;
    wait_drain("t3_drain");

    // Test 4: table-driven streaming, one request per cycle
    for (int i = 0; i < 32; i++) begin
      vecs[i].idx  = IDX_W'(i + 32);
      vecs[i].mcn  = (i % 5 == 4) ? ((MCN_W'(1) << MEM_AW) | MCN_W'(i)) : MCN_W'(i % 16);
      vecs[i].data = exp_data(vecs[i].mcn);
    end
    gaps = 0;
    for (int k = 0; k < 39; k++) begin
      if (k < 32) begin
        req_valid = 1'b1;
        req_idx   = vecs[k].idx;
        req_mcn   = vecs[k].mcn;
        if (!req_ready) gaps++;
        sb_q.push_back('{idx: vecs[k].idx, data: vecs[k].data});
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (res_valid != (k >= 3 && k <= 34)) gaps++;
    end
    req_valid = 1'b0;
    check("t4_stream_timing", DAT_W'(gaps), DAT_W'(0));
    wait_drain("t4_drain");

    // Test 5: preload of the line being popped in the same cycle wins
    check("t5_ready", DAT_W'(req_ready), DAT_W'(1));
    req_valid = 1'b1;
    req_idx   = 6'd9;
    req_mcn   = 58'd9;
    sb_q.push_back('{idx: 6'd9, data: xval});
    tick();
    req_valid = 1'b0;
    pre_valid = 1'b1;
    pre_mcn   = MEM_AW'(9);
    pre_data  = xval;
    tick();
    pre_valid = 1'b0;
    model_mem[9] = xval;
    send(6'd10, MCN_W'(1) << MEM_AW, '0);
    send(6'd11, (MCN_W'(1) << (MCN_W - 1)) | MCN_W'(5), '0);
    send(6'd12, 58'd9, xval);
    wait_drain("t5_drain");

    // Test 6: reset with three requests in flight drops them all
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_idx   = IDX_W'(20 + k);
      req_mcn   = MCN_W'(k);
      tick();
    end
    req_valid = 1'b0;
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    check("t6_busy", DAT_W'(busy), DAT_W'(0));
    check("t6_res_valid", DAT_W'(res_valid), DAT_W'(0));
    check("t6_ready", DAT_W'(req_ready), DAT_W'(1));
    seen = 0;
    repeat (5) begin
      tick();
      if (res_valid) seen++;
    end
    check("t6_quiet", DAT_W'(seen), DAT_W'(0));
    send(6'd7, 58'd5, a5);
    wait_drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
